// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem requests,
// and buffers fetched words with their PC in a 2-entry FIFO for decode.
module fetch_queue #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP_WORD = 16'h0800
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   input  logic        dec_ready,
   output logic        inst_valid,
   output logic [15:0] instruction,
   output logic [15:0] PC_out,
   output logic [15:0] next_PC_out,
   output logic        halted,
   output logic        err
);

   typedef enum logic [1:0] {FETCH, WAIT, DRAIN, HALTED} state_t;

   state_t      state, state_next;
   logic [15:0] pc;
   logic [15:0] fifo_instr [2];
   logic [15:0] fifo_pc [2];
   logic        rd_ptr, wr_ptr;
   logic [1:0]  count;
   logic        push, pop, is_halt, err_set;

   always_comb begin
      // Gated with rst_n so the request drops the instant reset asserts.
      imem_req = rst_n && (((state == FETCH) && (count < 2'd2) && !redirect_valid) ||
                           (state == WAIT) || (state == DRAIN));
      is_halt  = (imem_rdata[15:11] == 5'b00000);
      push     = imem_ack && !redirect_valid &&
                 (((state == FETCH) && imem_req) || (state == WAIT));
      pop      = inst_valid && dec_ready && !redirect_valid;
      err_set  = imem_ack && (((state == FETCH) && !imem_req) || (state == HALTED));
   end

   always_comb begin
      state_next = state;
      case (state)
         FETCH: begin
            if (!redirect_valid && imem_req) begin
               if (imem_ack) state_next = is_halt ? HALTED : FETCH;
               else          state_next = WAIT;
            end
         end
         WAIT: begin
            if (imem_ack)            state_next = (redirect_valid || !is_halt) ? FETCH : HALTED;
            else if (redirect_valid) state_next = DRAIN;
         end
         DRAIN: begin
            if (imem_ack) state_next = FETCH;
         end
         HALTED: begin
            if (redirect_valid) state_next = FETCH;
         end
         default: state_next = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
         pc    <= RESET_PC;
         err   <= 1'b0;
      end else begin
         state <= state_next;
         if (redirect_valid) pc <= redirect_pc;
         else if (push)      pc <= pc + 16'd2;
         if (err_set) err <= 1'b1;
      end
   end

   // Flush wins over push and pop; otherwise a simultaneous push/pop keeps count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else if (redirect_valid) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         if (push && !pop)      count <= count + 2'd1;
         else if (pop && !push) count <= count - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !redirect_valid) begin
         fifo_instr[wr_ptr] <= imem_rdata;
         fifo_pc[wr_ptr]    <= pc;
      end
   end

   always_comb begin
      inst_valid  = (count != 2'd0);
      instruction = inst_valid ? fifo_instr[rd_ptr] : NOP_WORD;
      PC_out      = inst_valid ? fifo_pc[rd_ptr] : pc;
      halted      = (state == HALTED) && (count == 2'd0);
   end

   assign next_PC_out = PC_out + 16'd2;
   assign imem_addr   = pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a behavioural imem with zero or N-cycle latency
// returns {5'b00001, addr[10:0]} (0x0000 at an optional halt address).
module tb_fetch_queue;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        dec_ready;
   logic        inst_valid;
   logic [15:0] instruction;
   logic [15:0] PC_out;
   logic [15:0] next_PC_out;
   logic        halted;
   logic        err;

   int          checks = 0;
   int          errors = 0;
   int          latency;
   int          lat_cnt;
   logic        force_ack;
   logic        halt_en;
   logic [15:0] halt_addr;

   fetch_queue dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec_ready(dec_ready),
      .inst_valid(inst_valid), .instruction(instruction), .PC_out(PC_out),
      .next_PC_out(next_PC_out), .halted(halted), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (halt_en && (a == halt_addr)) return 16'h0000;
      return {5'b00001, a[10:0]};
   endfunction

   assign imem_rdata = mem_word(imem_addr);
   assign imem_ack   = force_ack | ((latency == 0) ? imem_req : (imem_req && (lat_cnt == latency - 1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    lat_cnt <= 0;
      else if (!imem_req || imem_ack) lat_cnt <= 0;
      else                           lat_cnt <= lat_cnt + 1;
   end

   task automatic next_cyc;
      @(negedge clk);
   endtask

   // Returns at the negedge where rst_n rises; #1 later is cycle 0.
   task automatic do_reset(input int lat, input logic dr);
      rst_n = 1'b0;
      latency = lat;
      dec_ready = dr;
      redirect_valid = 1'b0;
      redirect_pc = 16'h0000;
      force_ack = 1'b0;
      halt_en = 1'b0;
      halt_addr = 16'h0000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      latency = 0;
      dec_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 16'h0000;
      force_ack = 1'b0;
      halt_en = 1'b0;
      halt_addr = 16'h0000;
      next_cyc();
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req got %b want 0", imem_req); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b want 0", inst_valid); end
      checks++; if (instruction !== 16'h0800) begin errors++; $display("[TB] FAIL rst_instr got %h want 0800", instruction); end
      checks++; if (PC_out !== 16'h0000) begin errors++; $display("[TB] FAIL rst_pc got %h want 0000", PC_out); end
      checks++; if (next_PC_out !== 16'h0002) begin errors++; $display("[TB] FAIL rst_npc got %h want 0002", next_PC_out); end
      checks++; if (halted !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL rst_flags got %b%b want 00", halted, err); end
   endtask

   task automatic test_stream;
      logic [15:0] exp_pc;
      do_reset(0, 1'b1);
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL stream_c0 got req=%b addr=%h want 1/0000", imem_req, imem_addr); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_c0_valid got %b want 0", inst_valid); end
      for (int k = 1; k <= 4; k++) begin
         next_cyc();
         #1;
         exp_pc = 16'(2 * (k - 1));
         checks++; if (inst_valid !== 1'b1 || PC_out !== exp_pc) begin errors++; $display("[TB] FAIL stream_pc%0d got v=%b pc=%h want 1/%h", k, inst_valid, PC_out, exp_pc); end
         checks++; if (next_PC_out !== exp_pc + 16'd2) begin errors++; $display("[TB] FAIL stream_npc%0d got %h want %h", k, next_PC_out, exp_pc + 16'd2); end
         checks++; if (instruction !== (16'h0800 | exp_pc)) begin errors++; $display("[TB] FAIL stream_instr%0d got %h want %h", k, instruction, 16'h0800 | exp_pc); end
      end
   endtask

   task automatic test_backpressure;
      do_reset(0, 1'b0);
      next_cyc();
      next_cyc();
      for (int c = 2; c <= 4; c++) begin
         #1;
         checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_c%0d got %b want 0", c, imem_req); end
         checks++; if (inst_valid !== 1'b1 || PC_out !== 16'h0000) begin errors++; $display("[TB] FAIL bp_head_c%0d got v=%b pc=%h want 1/0000", c, inst_valid, PC_out); end
         next_cyc();
      end
      dec_ready = 1'b1;
      #1;
      checks++; if (PC_out !== 16'h0000 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL bp_c5 got pc=%h req=%b want 0000/0", PC_out, imem_req); end
      next_cyc();
      #1;
      checks++; if (inst_valid !== 1'b1 || PC_out !== 16'h0002) begin errors++; $display("[TB] FAIL bp_c6_pc got v=%b pc=%h want 1/0002", inst_valid, PC_out); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin errors++; $display("[TB] FAIL bp_c6_req got %b/%h want 1/0004", imem_req, imem_addr); end
      next_cyc();
      #1;
      checks++; if (inst_valid !== 1'b1 || PC_out !== 16'h0004) begin errors++; $display("[TB] FAIL bp_c7_pc got v=%b pc=%h want 1/0004", inst_valid, PC_out); end
   endtask

   task automatic test_redirect_inflight;
      bit seen;
      do_reset(3, 1'b1);
      repeat (6) next_cyc();
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin errors++; $display("[TB] FAIL rd_c6_req got %b/%h want 1/0004", imem_req, imem_addr); end
      checks++; if (inst_valid !== 1'b1 || PC_out !== 16'h0002) begin errors++; $display("[TB] FAIL rd_c6_head got v=%b pc=%h want 1/0002", inst_valid, PC_out); end
      next_cyc();
      redirect_valid = 1'b1;
      redirect_pc = 16'h0100;
      next_cyc();
      redirect_valid = 1'b0;
      #1;
      checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rd_c8 got v=%b req=%b want 0/1", inst_valid, imem_req); end
      next_cyc();
      #1;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rd_c9_discard got v=%b pc=%h want 0", inst_valid, PC_out); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin errors++; $display("[TB] FAIL rd_c9_req got %b/%h want 1/0100", imem_req, imem_addr); end
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         next_cyc();
         #1;
         if (inst_valid === 1'b1) begin
            seen = 1'b1;
            checks++; if (PC_out !== 16'h0100) begin errors++; $display("[TB] FAIL rd_first_pc got %h want 0100", PC_out); end
         end
      end
      if (!seen) begin
         checks++; errors++;
         $display("[TB] FAIL rd_timeout got no valid want valid within 8 cycles");
      end
   endtask

   task automatic test_halt;
      do_reset(0, 1'b1);
      halt_en = 1'b1;
      halt_addr = 16'h0006;
      repeat (4) next_cyc();
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_c4_req got %b want 0", imem_req); end
      checks++; if (inst_valid !== 1'b1 || PC_out !== 16'h0006 || instruction !== 16'h0000) begin errors++; $display("[TB] FAIL halt_c4_head got v=%b pc=%h i=%h want 1/0006/0000", inst_valid, PC_out, instruction); end
      checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_c4_halted got %b want 0", halted); end
      next_cyc();
      #1;
      checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_c5 got h=%b req=%b v=%b want 1/0/0", halted, imem_req, inst_valid); end
      checks++; if (PC_out !== 16'h0008 || next_PC_out !== 16'h000A) begin errors++; $display("[TB] FAIL halt_c5_pc got %h/%h want 0008/000a", PC_out, next_PC_out); end
      next_cyc();
      redirect_valid = 1'b1;
      redirect_pc = 16'h0020;
      next_cyc();
      redirect_valid = 1'b0;
      #1;
      checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0020) begin errors++; $display("[TB] FAIL halt_resume got h=%b req=%b addr=%h want 0/1/0020", halted, imem_req, imem_addr); end
      next_cyc();
      #1;
      checks++; if (inst_valid !== 1'b1 || PC_out !== 16'h0020 || instruction !== 16'h0820) begin errors++; $display("[TB] FAIL halt_resume_head got v=%b pc=%h i=%h want 1/0020/0820", inst_valid, PC_out, instruction); end
   endtask

   task automatic test_wrap;
      do_reset(0, 1'b1);
      next_cyc();
      redirect_valid = 1'b1;
      redirect_pc = 16'hFFFE;
      next_cyc();
      redirect_valid = 1'b0;
      #1;
      checks++; if (inst_valid !== 1'b0 || imem_addr !== 16'hFFFE || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL wrap_c2 got v=%b addr=%h req=%b want 0/fffe/1", inst_valid, imem_addr, imem_req); end
      next_cyc();
      #1;
      checks++; if (PC_out !== 16'hFFFE || next_PC_out !== 16'h0000 || instruction !== 16'h0FFE) begin errors++; $display("[TB] FAIL wrap_c3_head got %h/%h/%h want fffe/0000/0ffe", PC_out, next_PC_out, instruction); end
      checks++; if (imem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_c3_addr got %h want 0000", imem_addr); end
      next_cyc();
      #1;
      checks++; if (inst_valid !== 1'b1 || PC_out !== 16'h0000 || next_PC_out !== 16'h0002) begin errors++; $display("[TB] FAIL wrap_c4 got v=%b %h/%h want 1/0000/0002", inst_valid, PC_out, next_PC_out); end
   endtask

   task automatic test_err;
      do_reset(0, 1'b0);
      repeat (3) next_cyc();
      force_ack = 1'b1;
      #1;
      checks++; if (err !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL err_c3 got err=%b req=%b want 0/0", err, imem_req); end
      next_cyc();
      force_ack = 1'b0;
      #1;
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_set got %b want 1", err); end
      checks++; if (inst_valid !== 1'b1 || PC_out !== 16'h0000) begin errors++; $display("[TB] FAIL err_fifo got v=%b pc=%h want 1/0000", inst_valid, PC_out); end
      repeat (2) next_cyc();
      #1;
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky got %b want 1", err); end
      rst_n = 1'b0;
      #1;
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_clear got %b want 0", err); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_inflight();
      test_halt();
      test_wrap();
      test_err();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
